// File: rtl/fitter_if.sv
// Term/result bundle for the fitter: per-hit coefficients, constant terms,
// hit coordinate and term/event strobes in; saturated results, overflow
// flags, result strobe and FSM state out.
interface fitter_if;
  logic signed [13:0] CHI1IN, CHI2IN, CHI3IN, PHIIN, DIN, CIN;
  logic signed [13:0] CHI10IN, CHI20IN, CHI30IN, PHI0IN, D0IN, C0IN;
  logic signed [14:0] HIN;
  logic               DV;
  logic               EV;
  logic signed [13:0] CHI1OUT, CHI2OUT, CHI3OUT;
  logic               CHI1OF, CHI2OF, CHI3OF;
  logic signed [12:0] PHIOUT;
  logic               PHIOF;
  logic signed [10:0] DOUT;
  logic               DOF;
  logic signed [7:0]  COUT;
  logic               COF;
  logic               READY;
  logic [1:0]         state_out;

  modport slave (
    input  CHI1IN, CHI2IN, CHI3IN, PHIIN, DIN, CIN,
    input  CHI10IN, CHI20IN, CHI30IN, PHI0IN, D0IN, C0IN,
    input  HIN, DV, EV,
    output CHI1OUT, CHI2OUT, CHI3OUT, CHI1OF, CHI2OF, CHI3OF,
    output PHIOUT, PHIOF, DOUT, DOF, COUT, COF,
    output READY, state_out
  );

  modport master (
    output CHI1IN, CHI2IN, CHI3IN, PHIIN, DIN, CIN,
    output CHI10IN, CHI20IN, CHI30IN, PHI0IN, D0IN, C0IN,
    output HIN, DV, EV,
    input  CHI1OUT, CHI2OUT, CHI3OUT, CHI1OF, CHI2OF, CHI3OF,
    input  PHIOUT, PHIOF, DOUT, DOF, COUT, COF,
    input  READY, state_out
  );
endinterface

// File: rtl/fitter.sv
// Six-channel track fitter: each channel accumulates X0 + sum(X*H) over the
// terms of an event in a 36-bit wrapping accumulator, then latches a
// saturated copy of every accumulator into its narrower output register.
module fitter (
  input  logic     CLOCK,
  input  logic     RESET,
  fitter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic signed [35:0] acc_q [6];
  logic signed [35:0] acc_d [6];
  logic signed [13:0] coef [6];
  logic signed [13:0] cst [6];
  logic signed [28:0] prod [6];
  logic signed [35:0] prod_ext [6];
  logic signed [35:0] cst_ext [6];

  logic signed [13:0] chi1_q, chi1_d, chi2_q, chi2_d, chi3_q, chi3_d;
  logic signed [12:0] phi_q, phi_d;
  logic signed [10:0] d_q, d_d;
  logic signed [7:0]  c_q, c_d;
  logic [5:0]         of_q, of_d;
  logic               ready_q, ready_d;

  // Clamp a 36-bit accumulator to a w-bit signed range (w <= 14); the
  // low w bits of the returned value are the output code.
  function automatic logic signed [13:0] sat_val(input logic signed [35:0] a,
                                                 input int w);
    logic signed [35:0] hi, lo;
    hi = (36'sd1 <<< (w - 1)) - 36'sd1;
    lo = ~hi;
    if (a > hi)      sat_val = hi[13:0];
    else if (a < lo) sat_val = lo[13:0];
    else             sat_val = a[13:0];
  endfunction

  // True when the accumulator does not fit a w-bit signed output.
  function automatic logic sat_ovf(input logic signed [35:0] a, input int w);
    logic signed [35:0] hi, lo;
    hi = (36'sd1 <<< (w - 1)) - 36'sd1;
    lo = ~hi;
    sat_ovf = (a > hi) || (a < lo);
  endfunction

  assign coef[0] = bus.CHI1IN;
  assign coef[1] = bus.CHI2IN;
  assign coef[2] = bus.CHI3IN;
  assign coef[3] = bus.PHIIN;
  assign coef[4] = bus.DIN;
  assign coef[5] = bus.CIN;
  assign cst[0]  = bus.CHI10IN;
  assign cst[1]  = bus.CHI20IN;
  assign cst[2]  = bus.CHI30IN;
  assign cst[3]  = bus.PHI0IN;
  assign cst[4]  = bus.D0IN;
  assign cst[5]  = bus.C0IN;

  // Full 14x15 signed products and sign-extended constants per channel.
  // Both operands are sign-extended to 29 bits, so the low 29 bits of the
  // product are the exact signed result.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      prod[i]     = {{15{coef[i][13]}}, coef[i]} * {{14{bus.HIN[14]}}, bus.HIN};
      prod_ext[i] = {{7{prod[i][28]}}, prod[i]};
      cst_ext[i]  = {{22{cst[i][13]}}, cst[i]};
    end
  end

  // Next state, accumulator update and result latch decisions.
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    for (int i = 0; i < 6; i++) acc_d[i] = acc_q[i];
    chi1_d  = chi1_q;
    chi2_d  = chi2_q;
    chi3_d  = chi3_q;
    phi_d   = phi_q;
    d_d     = d_q;
    c_d     = c_q;
    of_d    = of_q;
    case (state_q)
      IDLE: begin
        if (bus.DV) begin
          for (int i = 0; i < 6; i++) acc_d[i] = cst_ext[i] + prod_ext[i];
          state_d = bus.EV ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (bus.DV) begin
          for (int i = 0; i < 6; i++) acc_d[i] = acc_q[i] + prod_ext[i];
          if (bus.EV) state_d = DONE;
        end else if (bus.EV) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Publish the finished event; a term arriving now opens the next one.
        chi1_d  = sat_val(acc_q[0], 14);
        chi2_d  = sat_val(acc_q[1], 14);
        chi3_d  = sat_val(acc_q[2], 14);
        phi_d   = 13'(sat_val(acc_q[3], 13));
        d_d     = 11'(sat_val(acc_q[4], 11));
        c_d     = 8'(sat_val(acc_q[5], 8));
        of_d    = {sat_ovf(acc_q[5], 8), sat_ovf(acc_q[4], 11),
                   sat_ovf(acc_q[3], 13), sat_ovf(acc_q[2], 14),
                   sat_ovf(acc_q[1], 14), sat_ovf(acc_q[0], 14)};
        ready_d = 1'b1;
        if (bus.DV) begin
          for (int i = 0; i < 6; i++) acc_d[i] = cst_ext[i] + prod_ext[i];
          state_d = bus.EV ? DONE : ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, accumulators and result registers; reset clears everything.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      for (int i = 0; i < 6; i++) acc_q[i] <= '0;
      chi1_q  <= '0;
      chi2_q  <= '0;
      chi3_q  <= '0;
      phi_q   <= '0;
      d_q     <= '0;
      c_q     <= '0;
      of_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 6; i++) acc_q[i] <= acc_d[i];
      chi1_q  <= chi1_d;
      chi2_q  <= chi2_d;
      chi3_q  <= chi3_d;
      phi_q   <= phi_d;
      d_q     <= d_d;
      c_q     <= c_d;
      of_q    <= of_d;
      ready_q <= ready_d;
    end
  end

  assign bus.CHI1OUT   = chi1_q;
  assign bus.CHI2OUT   = chi2_q;
  assign bus.CHI3OUT   = chi3_q;
  assign bus.PHIOUT    = phi_q;
  assign bus.DOUT      = d_q;
  assign bus.COUT      = c_q;
  assign bus.CHI1OF    = of_q[0];
  assign bus.CHI2OF    = of_q[1];
  assign bus.CHI3OF    = of_q[2];
  assign bus.PHIOF     = of_q[3];
  assign bus.DOF       = of_q[4];
  assign bus.COF       = of_q[5];
  assign bus.READY     = ready_q;
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_fitter.sv
// Directed bench for the fitter: reset, accumulation, constants, output
// saturation, reset mid-event and back-to-back events.
module tb_fitter;
  logic CLOCK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  fitter_if bus ();

  fitter dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  logic [73:0] outs;
  logic [5:0]  ofs;
  assign outs = {bus.CHI1OUT, bus.CHI2OUT, bus.CHI3OUT, bus.PHIOUT, bus.DOUT, bus.COUT};
  assign ofs  = {bus.CHI1OF, bus.CHI2OF, bus.CHI3OF, bus.PHIOF, bus.DOF, bus.COF};

  // Expected output vector when every channel holds the same in-range value.
  function automatic logic [73:0] all_outs(input logic signed [13:0] v);
    all_outs = {v, v, v, v[12:0], v[10:0], v[7:0]};
  endfunction

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_all(input logic signed [13:0] k, input logic signed [13:0] c0,
                         input logic signed [14:0] h);
    bus.CHI1IN = k;   bus.CHI2IN = k;   bus.CHI3IN = k;
    bus.PHIIN = k;    bus.DIN = k;      bus.CIN = k;
    bus.CHI10IN = c0; bus.CHI20IN = c0; bus.CHI30IN = c0;
    bus.PHI0IN = c0;  bus.D0IN = c0;    bus.C0IN = c0;
    bus.HIN = h;
  endtask

  task automatic drive(input logic dv, input logic ev);
    bus.DV = dv;
    bus.EV = ev;
    step();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.DV = 1'b0;
    bus.EV = 1'b0;
    set_all(14'sd0, 14'sd0, 15'sd0);
    repeat (3) step();
    checks++;
    if (bus.state_out !== 2'd0) begin
      errors++; $display("FAIL reset_state got %0d exp 0", bus.state_out);
    end
    checks++;
    if (outs !== 74'd0) begin
      errors++; $display("FAIL reset_outs got %h exp 0", outs);
    end
    checks++;
    if (ofs !== 6'd0) begin
      errors++; $display("FAIL reset_of got %b exp 000000", ofs);
    end
    checks++;
    if (bus.READY !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b exp 0", bus.READY);
    end
    RESET = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic rdy_seen;
    rdy_seen = 1'b0;
    set_all(14'sd1, 14'sd0, 15'sd1);
    for (int i = 0; i < 7; i++) begin
      drive(i % 2 == 0, i == 6);
      if (bus.READY === 1'b1) rdy_seen = 1'b1;
      checks++;
      if (bus.state_out !== ((i == 6) ? 2'd2 : 2'd1)) begin
        errors++;
        $display("FAIL basic_state%0d got %0d exp %0d", i, bus.state_out, (i == 6) ? 2 : 1);
      end
    end
    checks++;
    if (rdy_seen !== 1'b0) begin
      errors++; $display("FAIL basic_early_ready got 1 exp 0");
    end
    drive(1'b0, 1'b0);
    checks++;
    if (bus.READY !== 1'b1) begin
      errors++; $display("FAIL basic_ready got %b exp 1", bus.READY);
    end
    checks++;
    if (outs !== all_outs(14'sd4)) begin
      errors++; $display("FAIL basic_outs got %h exp %h", outs, all_outs(14'sd4));
    end
    checks++;
    if (ofs !== 6'd0) begin
      errors++; $display("FAIL basic_of got %b exp 000000", ofs);
    end
    checks++;
    if (bus.state_out !== 2'd0) begin
      errors++; $display("FAIL basic_idle got %0d exp 0", bus.state_out);
    end
    drive(1'b0, 1'b0);
    checks++;
    if (bus.READY !== 1'b0) begin
      errors++; $display("FAIL basic_ready_pulse got %b exp 0", bus.READY);
    end
    checks++;
    if (outs !== all_outs(14'sd4)) begin
      errors++; $display("FAIL basic_hold got %h exp %h", outs, all_outs(14'sd4));
    end
  endtask

  task automatic test_const();
    set_all(14'sd2, 14'sd100, 15'sd3);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    checks++;
    if (bus.state_out !== 2'd2) begin
      errors++; $display("FAIL const_state got %0d exp 2", bus.state_out);
    end
    drive(1'b0, 1'b0);
    checks++;
    if (outs !== all_outs(14'sd112) || bus.READY !== 1'b1) begin
      errors++; $display("FAIL const_outs got %h rdy %b exp %h rdy 1", outs, bus.READY, all_outs(14'sd112));
    end
    checks++;
    if (ofs !== 6'd0) begin
      errors++; $display("FAIL const_of got %b exp 000000", ofs);
    end
  endtask

  task automatic test_saturation();
    // positive overflow on PHI/D/C, CHI1 exactly at its maximum
    set_all(14'sd0, 14'sd0, 15'sd1);
    bus.CIN = 14'sh1FFF; bus.DIN = 14'sh1FFF; bus.PHIIN = 14'sh1FFF; bus.CHI1IN = 14'sh1FFF;
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    checks++;
    if (outs !== {14'h1FFF, 14'h0000, 14'h0000, 13'h0FFF, 11'h3FF, 8'h7F}) begin
      errors++; $display("FAIL sat_pos_outs got %h exp %h", outs,
                         {14'h1FFF, 14'h0000, 14'h0000, 13'h0FFF, 11'h3FF, 8'h7F});
    end
    checks++;
    if (ofs !== 6'b000111) begin
      errors++; $display("FAIL sat_pos_of got %b exp 000111", ofs);
    end
    // negative overflow on PHI/C, CHI2 and D exactly at their minimum
    set_all(14'sd0, 14'sd0, 15'sd1);
    bus.CIN = 14'sh2000; bus.CHI2IN = 14'sh2000; bus.DIN = -14'sd1024; bus.PHIIN = -14'sd4097;
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    checks++;
    if (outs !== {14'h0000, 14'h2000, 14'h0000, 13'h1000, 11'h400, 8'h80}) begin
      errors++; $display("FAIL sat_neg_outs got %h exp %h", outs,
                         {14'h0000, 14'h2000, 14'h0000, 13'h1000, 11'h400, 8'h80});
    end
    checks++;
    if (ofs !== 6'b000101) begin
      errors++; $display("FAIL sat_neg_of got %b exp 000101", ofs);
    end
    // in-range edge values clear the flags
    set_all(14'sd0, 14'sd0, 15'sd1);
    bus.CIN = 14'sd127; bus.DIN = 14'sd1023; bus.CHI3IN = -14'sd5;
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    checks++;
    if (outs !== {14'h0000, 14'h0000, 14'h3FFB, 13'h0000, 11'h3FF, 8'h7F} || ofs !== 6'd0) begin
      errors++; $display("FAIL sat_edge got %h of %b exp %h of 000000", outs, ofs,
                         {14'h0000, 14'h0000, 14'h3FFB, 13'h0000, 11'h3FF, 8'h7F});
    end
  endtask

  task automatic test_reset_mid();
    logic rdy_seen;
    rdy_seen = 1'b0;
    set_all(14'sd1, 14'sd0, 15'sd1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    checks++;
    if (bus.state_out !== 2'd1) begin
      errors++; $display("FAIL rstmid_accum got %0d exp 1", bus.state_out);
    end
    RESET = 1'b1;
    drive(1'b1, 1'b1);
    RESET = 1'b0;
    checks++;
    if (bus.state_out !== 2'd0 || outs !== 74'd0 || ofs !== 6'd0) begin
      errors++; $display("FAIL rstmid_clear got st %0d outs %h of %b exp 0", bus.state_out, outs, ofs);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0);
      if (bus.READY === 1'b1) rdy_seen = 1'b1;
    end
    checks++;
    if (rdy_seen !== 1'b0) begin
      errors++; $display("FAIL rstmid_ready got 1 exp 0");
    end
    set_all(14'sd1, 14'sd0, 15'sd5);
    drive(1'b1, 1'b1);
    checks++;
    if (bus.READY !== 1'b0 || bus.state_out !== 2'd2) begin
      errors++; $display("FAIL rstmid_done got rdy %b st %0d exp rdy 0 st 2", bus.READY, bus.state_out);
    end
    drive(1'b0, 1'b0);
    checks++;
    if (outs !== all_outs(14'sd5) || bus.READY !== 1'b1) begin
      errors++; $display("FAIL rstmid_outs got %h rdy %b exp %h rdy 1", outs, bus.READY, all_outs(14'sd5));
    end
  endtask

  task automatic test_back_to_back();
    set_all(14'sd1, 14'sd10, 15'sd2);
    drive(1'b1, 1'b1);
    set_all(14'sd3, 14'sd20, 15'sd4);
    drive(1'b1, 1'b0);
    checks++;
    if (outs !== all_outs(14'sd12) || bus.READY !== 1'b1 || bus.state_out !== 2'd1) begin
      errors++; $display("FAIL b2b_first got %h rdy %b st %0d exp %h rdy 1 st 1",
                         outs, bus.READY, bus.state_out, all_outs(14'sd12));
    end
    set_all(14'sd3, 14'sd50, 15'sd4);
    drive(1'b1, 1'b1);
    checks++;
    if (outs !== all_outs(14'sd12) || bus.READY !== 1'b0 || bus.state_out !== 2'd2) begin
      errors++; $display("FAIL b2b_hold got %h rdy %b st %0d exp %h rdy 0 st 2",
                         outs, bus.READY, bus.state_out, all_outs(14'sd12));
    end
    drive(1'b0, 1'b0);
    checks++;
    if (outs !== all_outs(14'sd44) || bus.READY !== 1'b1 || ofs !== 6'd0) begin
      errors++; $display("FAIL b2b_second got %h rdy %b of %b exp %h rdy 1 of 000000",
                         outs, bus.READY, ofs, all_outs(14'sd44));
    end
    checks++;
    if (bus.state_out !== 2'd0) begin
      errors++; $display("FAIL b2b_idle got %0d exp 0", bus.state_out);
    end
  endtask

  initial begin
    RESET  = 1'b1;
    bus.DV = 1'b0;
    bus.EV = 1'b0;
    test_reset();
    test_basic();
    test_const();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
